// File: rtl/mips_dbg_pkg.sv
// Shared definitions for the MIPS end-of-program monitor: dump FSM states,
// halt detection modes and the defaults matching the fib test program.
package mips_dbg_pkg;

    typedef enum logic [1:0] {
        ST_WAIT    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_PRESENT = 2'd2,
        ST_DONE    = 2'd3
    } dump_state_t;

    localparam int HALT_PC_MATCH = 0;
    localparam int HALT_PC_STALL = 1;

    localparam logic [31:0] FIB_END_PC    = 32'h54;
    localparam int          FIB_BASE_WORD = 16;
    localparam int          FIB_COUNT     = 15;
    localparam logic [31:0] FIB_CHECKSUM  = 32'h63C;

endpackage

// File: rtl/pc_halt_detector.sv
// Program-completion detector: PC match or PC stall trigger plus cycle-count
// timeout. Counters only advance while armed (dump FSM waiting).
module pc_halt_detector
    import mips_dbg_pkg::*;
#(
    parameter int            AW            = 32,
    parameter logic [AW-1:0] END_PC        = AW'(FIB_END_PC),
    parameter int            HALT_MODE     = HALT_PC_MATCH,
    parameter int            STABLE_CYCLES = 4,
    parameter int            MAX_CYCLES    = 100000
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          arm,
    input  logic [AW-1:0] pc_i,
    output logic          trigger_o,
    output logic          timeout_o
);

    localparam logic [31:0] STABLE_LAST = 32'(STABLE_CYCLES - 1);
    localparam logic [31:0] CYCLE_LAST  = 32'(MAX_CYCLES - 1);

    logic [AW-1:0] prev_pc;
    logic [31:0]   stable_cnt;
    logic [31:0]   stable_next;
    logic [31:0]   cycle_cnt;
    logic          pc_hit;

    // The stall trigger fires on the edge where the count reaches its limit.
    always_comb begin
        stable_next = '0;
        pc_hit      = 1'b0;
        if (pc_i == prev_pc) begin
            stable_next = (stable_cnt == '1) ? stable_cnt : stable_cnt + 32'd1;
        end
        if (HALT_MODE == HALT_PC_STALL) begin
            pc_hit = (stable_next == STABLE_LAST);
        end else begin
            pc_hit = (pc_i == END_PC);
        end
        trigger_o = arm && pc_hit;
        timeout_o = arm && !pc_hit && (MAX_CYCLES != 0) && (cycle_cnt == CYCLE_LAST);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_pc    <= '0;
            stable_cnt <= '0;
            cycle_cnt  <= '0;
        end else if (arm) begin
            prev_pc    <= pc_i;
            stable_cnt <= stable_next;
            if (cycle_cnt != '1) begin
                cycle_cnt <= cycle_cnt + 32'd1;
            end
        end
    end

endmodule

// File: rtl/pc_halt_dump_unit.sv
// End-of-program monitor: waits for halt or timeout, then streams a window of
// data memory over valid/ready while accumulating a pass/fail checksum.
module pc_halt_dump_unit
    import mips_dbg_pkg::*;
#(
    parameter int            AW            = 32,
    parameter int            DW            = 32,
    parameter logic [AW-1:0] END_PC        = AW'(FIB_END_PC),
    parameter int            HALT_MODE     = HALT_PC_MATCH,
    parameter int            STABLE_CYCLES = 4,
    parameter int            BASE_WORD     = FIB_BASE_WORD,
    parameter int            COUNT         = FIB_COUNT,
    parameter int            RD_LAT        = 0,
    parameter int            MAX_CYCLES    = 100000,
    parameter int            CHECK_EN      = 1,
    parameter logic [DW-1:0] EXPECT_SUM    = DW'(FIB_CHECKSUM)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] pc_i,
    output logic [AW-1:0] mem_rd_addr_o,
    input  logic [DW-1:0] mem_rd_data_i,
    output logic          dump_valid_o,
    input  logic          dump_ready_i,
    output logic [DW-1:0] dump_data_o,
    output logic [AW-1:0] dump_index_o,
    output logic          busy_o,
    output logic          done_o,
    output logic          timeout_o,
    output logic          pass_o,
    output logic [DW-1:0] checksum_o
);

    localparam logic [AW-1:0] BASE     = AW'(BASE_WORD);
    localparam logic [AW-1:0] LAST_IDX = AW'(COUNT - 1);
    localparam logic          LAT_WAIT = (RD_LAT != 0);

    dump_state_t   state;
    logic [AW-1:0] idx;
    logic [DW-1:0] data_q;
    logic          rd_wait;
    logic          trigger;
    logic          timeout_pulse;

    pc_halt_detector #(
        .AW            (AW),
        .END_PC        (END_PC),
        .HALT_MODE     (HALT_MODE),
        .STABLE_CYCLES (STABLE_CYCLES),
        .MAX_CYCLES    (MAX_CYCLES)
    ) u_detector (
        .clk       (clk),
        .reset     (reset),
        .arm       (state == ST_WAIT),
        .pc_i      (pc_i),
        .trigger_o (trigger),
        .timeout_o (timeout_pulse)
    );

    // Outputs are gated by registered flags so reset forces them all to zero.
    assign mem_rd_addr_o = busy_o ? BASE + idx : '0;
    assign dump_index_o  = dump_valid_o ? idx : '0;
    assign dump_data_o   = !dump_valid_o ? '0 : (LAT_WAIT ? data_q : mem_rd_data_i);
    assign pass_o        = done_o && !timeout_o &&
                           ((checksum_o == EXPECT_SUM) || (CHECK_EN == 0));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_WAIT;
            idx          <= '0;
            data_q       <= '0;
            rd_wait      <= 1'b0;
            checksum_o   <= '0;
            dump_valid_o <= 1'b0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            timeout_o    <= 1'b0;
        end else begin
            unique case (state)
                ST_WAIT: begin
                    if (trigger || timeout_pulse) begin
                        state     <= ST_ISSUE;
                        busy_o    <= 1'b1;
                        timeout_o <= timeout_pulse;
                        rd_wait   <= LAT_WAIT;
                    end
                end
                ST_ISSUE: begin
                    if (rd_wait) begin
                        rd_wait <= 1'b0;
                    end else begin
                        data_q       <= mem_rd_data_i;
                        state        <= ST_PRESENT;
                        dump_valid_o <= 1'b1;
                    end
                end
                ST_PRESENT: begin
                    if (dump_ready_i) begin
                        checksum_o   <= checksum_o + dump_data_o;
                        dump_valid_o <= 1'b0;
                        if (idx == LAST_IDX) begin
                            state  <= ST_DONE;
                            busy_o <= 1'b0;
                            done_o <= 1'b1;
                        end else begin
                            idx     <= idx + AW'(1);
                            state   <= ST_ISSUE;
                            rd_wait <= LAT_WAIT;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_DONE;
                end
                default: begin
                    state <= ST_WAIT;
                end
            endcase
        end
    end

endmodule
